// File: rtl/clock_pkg.sv
// Shared display constants and types for the clock display blocks.
// Active-low 7-segment table (bit0 = segment a), blanking values, scan FSM states.
package clock_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [5:0] DIG_OFF = 6'h3F;

  // Index 0 is the rightmost entry; codes 10..15 light only segment g.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [1:0] hh;
    logic [3:0] hl;
    logic [2:0] mh;
    logic [3:0] ml;
    logic [2:0] sh;
    logic [3:0] sl;
  } hms_t;

  // Digit positions 0/1 are seconds, 2/3 minutes, 4/5 hours.
  function automatic logic [1:0] field_of(input logic [2:0] idx);
    return idx[2:1];
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational 4-bit BCD to active-low 7-segment decoder; non-BCD codes show "-".
module seg7_dec
  import clock_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[bcd_i];

endmodule

// File: rtl/seg7_scan.sv
// Six-digit multiplexed 7-segment scanner with per-slot blanking, frame snapshot and field blink.
// All outputs registered: they follow the scan state one cycle later; EN low freezes the scan dark.
module seg7_scan
  import clock_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 8,
  parameter int BLINK_FRM = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [1:0] HH,
  input  logic [3:0] HL,
  input  logic [2:0] MH,
  input  logic [3:0] ML,
  input  logic [2:0] SH,
  input  logic [3:0] SL,
  input  logic [2:0] BLINK,
  output logic [6:0] SEG,
  output logic [5:0] DIG,
  output logic       DP,
  output logic       FRM
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRM > 1) ? $clog2(BLINK_FRM) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRM - 1);

  scan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          blink_off_q, blink_off_d;
  logic [2:0]    blink_req_q, blink_req_d;
  hms_t          snap_q, snap_d;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    dig_q, dig_d;
  logic          dp_q, dp_d;
  logic          frm_q, frm_d;

  logic       slot_start;
  logic       frame_start;
  logic [3:0] digit;
  logic [6:0] digit_seg;
  logic       dark;

  assign slot_start  = EN && (cnt_q == '0);
  assign frame_start = slot_start && (idx_q == 3'd0);

  always_comb begin
    digit = 4'd0;
    case (idx_q)
      3'd0:    digit = snap_q.sl;
      3'd1:    digit = {1'b0, snap_q.sh};
      3'd2:    digit = snap_q.ml;
      3'd3:    digit = {1'b0, snap_q.mh};
      3'd4:    digit = snap_q.hl;
      default: digit = {2'b00, snap_q.hh};
    endcase
  end

  seg7_dec u_dec (
    .bcd_i (digit),
    .seg_o (digit_seg)
  );

  // Hours-tens leading zero, or a blinking field in its off half-period.
  assign dark = ((idx_q == 3'd5) && (snap_q.hh == 2'd0)) ||
                (blink_off_q && blink_req_q[field_of(idx_q)]);

  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    fcnt_d      = fcnt_q;
    blink_off_d = blink_off_q;
    blink_req_d = blink_req_q;
    snap_d      = snap_q;
    seg_d       = SEG_OFF;
    dig_d       = DIG_OFF;
    dp_d        = 1'b1;
    frm_d       = 1'b0;

    if (EN) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (idx_q == 3'd5) begin
          idx_d = 3'd0;
          if (fcnt_q == FRM_LAST) begin
            fcnt_d      = '0;
            blink_off_d = ~blink_off_q;
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end

      if (slot_start) begin
        blink_req_d = BLINK;
      end
      if (frame_start) begin
        frm_d  = 1'b1;
        snap_d = '{hh: HH, hl: HL, mh: MH, ml: ML, sh: SH, sl: SL};
      end

      if (state_q == S_DRIVE) begin
        dig_d = ~(6'b000001 << idx_q);
        seg_d = dark ? SEG_OFF : digit_seg;
        dp_d  = !(!blink_off_q && ((idx_q == 3'd2) || (idx_q == 3'd4)));
      end
    end

    state_d = (cnt_d < CNT_BLANK) ? S_BLANK : S_DRIVE;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_BLANK;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      fcnt_q      <= '0;
      blink_off_q <= 1'b0;
      blink_req_q <= 3'b000;
      snap_q      <= '0;
      seg_q       <= SEG_OFF;
      dig_q       <= DIG_OFF;
      dp_q        <= 1'b1;
      frm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      fcnt_q      <= fcnt_d;
      blink_off_q <= blink_off_d;
      blink_req_q <= blink_req_d;
      snap_q      <= snap_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
      dp_q        <= dp_d;
      frm_q       <= frm_d;
    end
  end

  assign SEG = seg_q;
  assign DIG = dig_q;
  assign DP  = dp_q;
  assign FRM = frm_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomised bench for seg7_scan against a position-arithmetic reference model.
module tb_seg7_scan;

  localparam int SD = 16;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FRAME = 6 * SD;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN  = 1'b1;
  logic [1:0] HH = 2'd1;
  logic [3:0] HL = 4'd2;
  logic [2:0] MH = 3'd3;
  logic [3:0] ML = 4'd4;
  logic [2:0] SH = 3'd5;
  logic [3:0] SL = 4'd6;
  logic [2:0] BLINK = 3'b000;
  logic [6:0] SEG;
  logic [5:0] DIG;
  logic       DP;
  logic       FRM;

  int n_checks = 0;
  int n_errors = 0;

  // Model: m_pos counts enabled cycles since reset; everything else derives from it.
  int         m_pos = 0;
  int         m_digits[6];
  logic [2:0] m_blink = 3'b000;
  logic [6:0] exp_seg;
  logic [5:0] exp_dig;
  logic       exp_dp;
  logic       exp_frm;

  seg7_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRM(BF)) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .HH(HH), .HL(HL), .MH(MH), .ML(ML), .SH(SH), .SL(SL),
    .BLINK(BLINK),
    .SEG(SEG), .DIG(DIG), .DP(DP), .FRM(FRM)
  );

  always #5 CLK = ~CLK;

  // Textbook active-high segment sets (gfedcba), inverted for the active-low pins.
  function automatic logic [6:0] ref_seg(input int v);
    logic [6:0] lit;
    case (v)
      0: lit = 7'h3F;  1: lit = 7'h06;  2: lit = 7'h5B;  3: lit = 7'h4F;
      4: lit = 7'h66;  5: lit = 7'h6D;  6: lit = 7'h7D;  7: lit = 7'h07;
      8: lit = 7'h7F;  9: lit = 7'h6F;
      default: lit = 7'h40;
    endcase
    return ~lit;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int c, i, frame;
    bit on;
    exp_seg = 7'h7F;
    exp_dig = 6'h3F;
    exp_dp  = 1'b1;
    exp_frm = 1'b0;
    if (!RST) begin
      m_pos = 0;
      foreach (m_digits[k]) m_digits[k] = 0;
      m_blink = 3'b000;
      return;
    end
    if (!EN) return;
    c     = m_pos % SD;
    i     = (m_pos / SD) % 6;
    frame = m_pos / FRAME;
    if (c == 0 && i == 0) begin
      exp_frm = 1'b1;
      m_digits[0] = int'(SL); m_digits[1] = int'(SH);
      m_digits[2] = int'(ML); m_digits[3] = int'(MH);
      m_digits[4] = int'(HL); m_digits[5] = int'(HH);
    end
    if (c == 0) m_blink = BLINK;
    if (c >= BC) begin
      on      = ((frame / BF) % 2) == 0;
      exp_dig = ~6'(1 << i);
      if ((i == 5 && m_digits[5] == 0) || (!on && m_blink[i / 2]))
        exp_seg = 7'h7F;
      else
        exp_seg = ref_seg(m_digits[i]);
      exp_dp = !(on && (i == 2 || i == 4));
    end
    m_pos++;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    chk("SEG", 32'(SEG), 32'(exp_seg));
    chk("DIG", 32'(DIG), 32'(exp_dig));
    chk("DP",  32'(DP),  32'(exp_dp));
    chk("FRM", 32'(FRM), 32'(exp_frm));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic align(input int m);
    run((m - (m_pos % m)) % m);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    HH = 2'(h / 10); HL = 4'(h % 10);
    MH = 3'(m / 10); ML = 4'(m % 10);
    SH = 3'(s / 10); SL = 4'(s % 10);
  endtask

  initial begin
    // Reset held for three cycles, outputs dark throughout.
    run(3);
    chk("rst_dig", 32'(DIG), 32'h3F);
    chk("rst_seg", 32'(SEG), 32'h7F);
    RST = 1'b1;

    // First slot after release: FRM, two blank cycles, then seconds units.
    tick();
    chk("first_frm", 32'(FRM), 32'd1);
    chk("first_dig", 32'(DIG), 32'h3F);
    tick();
    chk("blank2_dig", 32'(DIG), 32'h3F);
    tick();
    chk("drive0_dig", 32'(DIG), 32'h3E);
    chk("drive0_seg", 32'(SEG), 32'h02);
    run(80);
    chk("drive5_dig", 32'(DIG), 32'h1F);
    chk("drive5_seg", 32'(SEG), 32'h79);

    // Carry mid-frame must not leak into the frame already snapshotted.
    set_time(9, 59, 59);
    align(FRAME);
    run(20);
    set_time(10, 0, 0);
    tick();
    chk("carry_hold", 32'(SEG), 32'h12);
    run(FRAME);
    chk("carry_next", 32'(SEG), 32'h40);

    // Leading-zero suppression and dash for a non-BCD code.
    set_time(5, 0, 0);
    align(FRAME);
    run(83);
    chk("lz_tens_dig", 32'(DIG), 32'h1F);
    chk("lz_tens_seg", 32'(SEG), 32'h7F);
    HL = 4'd15;
    align(FRAME);
    run(67);
    chk("dash_dig", 32'(DIG), 32'h2F);
    chk("dash_seg", 32'(SEG), 32'h3F);
    run(16);
    chk("lz_tens2", 32'(SEG), 32'h7F);

    // EN low mid-slot freezes the scan, resume picks up at the held count.
    set_time(12, 34, 56);
    align(FRAME);
    run(7);
    EN = 1'b0;
    run(20);
    chk("en_off_dig", 32'(DIG), 32'h3F);
    EN = 1'b1;
    tick();
    chk("en_resume", 32'(DIG), 32'h3E);
    run(8);
    tick();
    chk("en_blank_a", 32'(DIG), 32'h3F);
    tick();
    chk("en_blank_b", 32'(DIG), 32'h3F);
    tick();
    chk("en_slot1", 32'(DIG), 32'h3D);

    // Minute field blinks: dark in the off phase, lit in the on phase.
    BLINK = 3'b010;
    align(4 * FRAME);
    run(2 * FRAME + 35);
    chk("blink_off_seg", 32'(SEG), 32'h7F);
    chk("blink_off_dp", 32'(DP), 32'd1);
    run(2 * FRAME);
    chk("blink_on_seg", 32'(SEG), 32'h19);
    chk("blink_on_dp", 32'(DP), 32'd0);

    // Reset in the middle of a driven slot blanks outputs immediately.
    align(SD);
    run(5);
    RST = 1'b0;
    #1;
    chk("rst_mid_seg", 32'(SEG), 32'h7F);
    chk("rst_mid_dig", 32'(DIG), 32'h3F);
    chk("rst_mid_dp",  32'(DP),  32'd1);
    chk("rst_mid_frm", 32'(FRM), 32'd0);
    run(3);
    RST = 1'b1;
    run(2 * FRAME);

    // Randomised traffic: time values (some non-BCD), blink requests and EN gaps.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 5) begin
        HH = 2'($urandom_range(0, 2));
        HL = 4'($urandom_range(0, 99) < 10 ? $urandom_range(10, 15) : $urandom_range(0, 9));
        MH = 3'($urandom_range(0, 7));
        ML = 4'($urandom_range(0, 15));
        SH = 3'($urandom_range(0, 5));
        SL = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 99) < 2) BLINK = 3'($urandom_range(0, 7));
      if (EN && $urandom_range(0, 99) < 2) EN = 1'b0;
      else if (!EN && $urandom_range(0, 99) < 20) EN = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning CLK cycles per digit slot (blank plus drive), legal range 16..65535.
REQ-002 SHALL have parameter BLANK_CYC, default 8, meaning CLK cycles of all-digits-off at the start of each slot, legal range 1..SCAN_DIV-8.
REQ-003 SHALL have parameter BLINK_FRM, default 32, meaning frames per blink half-period, legal range 1..255.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port EN, input, 1 bit: scan enable; when low, the scan freezes and all digits are off.
REQ-007 SHALL have ports HH, input, 2 bits; HL, input, 4 bits: hours tens and units, BCD.
REQ-008 SHALL have ports MH, input, 3 bits; ML, input, 4 bits: minutes tens and units, BCD, driven from CNT60 QH/QL.
REQ-009 SHALL have ports SH, input, 3 bits; SL, input, 4 bits: seconds tens and units, BCD, driven from CNT60 QH/QL.
REQ-010 SHALL have port BLINK, input, 3 bits: per-field blink request; bit0 is seconds, bit1 minutes, bit2 hours.
REQ-011 SHALL have port SEG, output, 7 bits: segments a..g, active-low (bit0=a).
REQ-012 SHALL have port DIG, output, 6 bits: digit enables, active-low one-hot; bit0 is seconds units and bit5 is hours tens.
REQ-013 SHALL have port DP, output, 1 bit: active-low colon/dp; lit on DIG bits 2 and 4 during the blink-on phase only.
REQ-014 SHALL have port FRM, output, 1 bit: a one-cycle pulse on the first cycle of digit slot 0.

Function
REQ-015 SHALL hold a slot counter 0..SCAN_DIV-1 and a digit index 0..5; the index advances and wraps 5->0 when the slot counter wraps.
REQ-016 SHALL use a two-state FSM per slot: BLANK for slot counts 0..BLANK_CYC-1, then DRIVE for the rest of the slot.
REQ-017 In BLANK, DIG SHALL be all-ones, SEG all-ones and DP high.
REQ-018 In DRIVE, DIG SHALL have exactly the index bit low and SEG SHALL show the snapshot digit for that index.
REQ-019 SHALL snapshot all six BCD inputs in the cycle FRM asserts, so that one frame never mixes values across a carry (e.g. 09:59 to 10:00).
REQ-020 SHALL register all outputs: SEG/DIG reflect the FSM state and index one cycle after that state is entered.
REQ-021 SHALL decode BCD 0..9 to standard 7-segment patterns; 10..15 SHALL display segment g only ("-").
REQ-022 SHALL blank the hours-tens digit (SEG all-ones, DIG still cycled) when HH snapshot equals 0 (leading-zero suppression).
REQ-023 SHALL count frames modulo BLINK_FRM and toggle a blink phase on each wrap; during the off phase, digits of fields with BLINK set SHALL show SEG all-ones.
REQ-024 EN low SHALL hold slot counter, index, frame and blink counters; outputs SHALL go inactive on the next edge; EN high SHALL resume from the held position, starting in the state matching the held count.
REQ-025 BLINK changes SHALL take effect at the next slot boundary, never mid-slot.
REQ-026 EN falling in the same cycle as a slot wrap SHALL freeze with the wrap applied (index already advanced).

Reset
REQ-027 RST low SHALL immediately force SEG=7'h7F, DIG=6'h3F, DP=1, FRM=0.
REQ-028 RST low SHALL immediately force the slot counter, index, frame counter and blink phase (on) to 0, and the snapshot to 00:00:00.
REQ-029 After RST release with EN high, the first slot SHALL be index 0 in BLANK with FRM asserted, and the snapshot SHALL be taken on that cycle.
REQ-030 RST mid-slot SHALL abandon the slot, with no partial digit left driven.

Structure
REQ-031 SHALL take the BCD-to-7-segment pattern table and the SEG_OFF/DIG_OFF constants from shared package clock_pkg.
REQ-032 SHALL contain one sub-module, seg7_dec: a combinational 4-bit BCD to 7-bit active-low decoder, reused by future display blocks.
REQ-033 SHALL keep the slot, frame and blink counters sized by $clog2 of their parameters, with no width truncation warnings.

Verification
REQ-034 Test reset/idle: RST low 3 cycles, then high with EN=1, SCAN_DIV=16, BLANK_CYC=2 -> FRM pulses on cycle 1; DIG=3F for 2 cycles, then DIG=3E.
REQ-035 Test decode: inputs 12:34:56 -> across one frame, DIG 3E/3D/3B/37/2F/1F paired with SEG for 6,5,4,3,2,1 (6 -> 7'h02, 1 -> 7'h79).
REQ-036 Test snapshot under carry: SL changes 9->0 and SH 5->0 in the middle of a frame -> that frame still shows 59; the next frame shows 00.
REQ-037 Test leading-zero: input 05:00:00 -> hours-tens slot has SEG=7F; with HL=15 the hours-units slot has SEG=7'h3F (g only).
REQ-038 Test blink: BLINK=3'b010, BLINK_FRM=2 -> minute digits dark for 2 frames, then lit for 2 frames; other digits are lit throughout.
REQ-039 Test EN/RST mid-slot: EN low at slot count 7 for 20 cycles -> DIG=3F and the counters are held, then the slot resumes at count 7; RST pulse mid-slot -> outputs go off at once.
